// File: rtl/addsub_seq.sv
// addsub_seq: multi-word add/subtract sequencer driving one shared 32-bit adder, LSW first
module addsub_seq #(
   parameter int WORDS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [32*WORDS-1:0]   inA,
   input  logic [32*WORDS-1:0]   inB,
   output logic                  busy,
   output logic                  done,
   output logic [32*WORDS-1:0]   out,
   output logic                  carry,
   output logic                  overFlow,
   output logic [31:0]           addA,
   output logic [31:0]           addB,
   output logic                  addCin,
   output logic                  addMode,
   input  logic [31:0]           addOut,
   input  logic                  addCarry,
   input  logic                  addOverFlow
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WORDS-1:0][31:0] op_a, op_b, res;
   logic [31:0] a_w, b_w;
   logic [2:0] idx;
   logic mode_r, c_r, run, last;
   assign out = res;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         res      <= '0;
         carry    <= 1'b0;
         overFlow <= 1'b0;
         idx      <= 3'd0;
         c_r      <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            op_a   <= inA;
            op_b   <= inB;
            mode_r <= mode;
            idx    <= 3'd0;
         end
         if (run) begin
            for (int i = 0; i < WORDS; i++)
               if (idx == 3'(i)) res[i] <= addOut;
            c_r <= addCarry;
            if (last) begin
               carry    <= addCarry;
               overFlow <= addOverFlow;
            end else idx <= idx + 3'd1;
         end
      end
   end
   always_comb begin
      run      = state == RUN;
      last     = idx == 3'(WORDS - 1);
      busy     = state != IDLE;
      done     = state == DONE;
      state_nx = state == IDLE ? (start ? RUN : IDLE) : run ? (last ? DONE : RUN) : IDLE;
      a_w = '0;
      b_w = '0;
      for (int i = 0; i < WORDS; i++)
         if (idx == 3'(i)) begin
            a_w = op_a[i];
            b_w = op_b[i];
         end
      // word 0 takes mode as carry-in so subtraction gets its +1
      addA    = run ? a_w : '0;
      addB    = run ? b_w : '0;
      addMode = run & mode_r;
      addCin  = run & (idx == 3'd0 ? mode_r : c_r);
   end
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed scoreboard bench for addsub_seq with WORDS=2 and a behavioural 32-bit adder
module tb_addsub_seq;
   logic clk = 1'b0, rst_n, start, mode;
   logic [63:0] inA, inB, out;
   logic busy, done, carry, overFlow;
   logic [31:0] addA, addB, addOut;
   logic addCin, addMode, addCarry, addOverFlow;
   typedef struct packed {logic [63:0] o; logic c; logic v;} res_t;
   res_t q[$];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   addsub_seq #(.WORDS(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .inA(inA), .inB(inB),
      .busy(busy), .done(done), .out(out), .carry(carry), .overFlow(overFlow),
      .addA(addA), .addB(addB), .addCin(addCin), .addMode(addMode),
      .addOut(addOut), .addCarry(addCarry), .addOverFlow(addOverFlow)
   );
   logic [31:0] bw;
   logic [32:0] sw;
   always_comb begin
      bw          = addMode ? ~addB : addB;
      sw          = {1'b0, addA} + {1'b0, bw} + {32'd0, addCin};
      addOut      = sw[31:0];
      addCarry    = sw[32];
      addOverFlow = (addA[31] == bw[31]) && (sw[31] != addA[31]);
   end
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic m);
      logic [63:0] bb;
      logic [64:0] s;
      res_t r;
      bb  = m ? ~b : b;
      s   = {1'b0, a} + {1'b0, bb} + {64'd0, m};
      r.o = s[63:0];
      r.c = s[64];
      r.v = (a[63] == bb[63]) && (s[63] != a[63]);
      return r;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic m, input bit poke);
      res_t r;
      int k;
      inA = a; inB = b; mode = m; start = 1'b1;
      q.push_back(model(a, b, m));
      @(negedge clk);
      start = poke;
      inA = ~a; inB = a ^ b; mode = ~m;
      chk({tag, " busy_run"}, {63'd0, busy}, 64'd1);
      chk({tag, " done_early"}, {63'd0, done}, 64'd0);
      k = 1;
      while (!done && k < 10) begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end
      chk({tag, " latency"}, 64'(k), 64'd3);
      if (q.size() != 0) begin
         r = q.pop_front();
         if (done) begin
            chk({tag, " out"}, out, r.o);
            chk({tag, " carry"}, {63'd0, carry}, {63'd0, r.c});
            chk({tag, " overflow"}, {63'd0, overFlow}, {63'd0, r.v});
         end
      end
      @(negedge clk);
      chk({tag, " done_pulse"}, {62'd0, done, busy}, 64'd0);
      chk({tag, " out_hold"}, out, r.o);
   endtask
   initial begin
      rst_n = 1'b0; start = 1'b1; mode = 1'b1;
      inA = 64'h1234_5678_9ABC_DEF0; inB = 64'h0FED_CBA9_8765_4321;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset flags", {60'd0, busy, done, carry, overFlow}, 64'd0);
         chk("reset out", out, 64'd0);
      end
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("idle after reset", {62'd0, busy, done}, 64'd0);
      chk("idle adder", {30'd0, addA, addCin, addMode}, 64'd0);
      run_op("add_chain", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      chk("add_chain lit", out, 64'h0000_0001_0000_0000);
      run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      chk("add_wrap lit", {out, carry, overFlow} >> 2, {64'hFFFF_FFFF_FFFF_FFFE, 2'b10} >> 2);
      chk("add_wrap flags", {62'd0, carry, overFlow}, 64'b10);
      run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      chk("add_ovf flags", {62'd0, carry, overFlow}, 64'b01);
      run_op("sub_borrow", 64'h1_0000_0000, 64'h1, 1'b1, 1'b0);
      chk("sub_borrow lit", out, 64'h0000_0000_FFFF_FFFF);
      chk("sub_borrow carry", {63'd0, carry}, 64'd1);
      run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
      chk("sub_ovf lit", out, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("sub_ovf flag", {63'd0, overFlow}, 64'd1);
      run_op("ignored_start", 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
      chk("ignored_start idle", {62'd0, busy, done}, 64'd0);
      inA = 64'h5; inB = 64'h3; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst cleared", {62'd0, busy, done}, 64'd0);
      chk("midrst out", out, 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("midrst no done", {63'd0, done}, 64'd0);
      end
      run_op("after_rst", 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0002, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)
         run_op("random", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'b0);
      chk("scoreboard empty", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
